// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding
// (also used by the trigger detector) and a small edge helper.
package stopwatch_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    S_IDLE    = 2'b00,
    S_RUNNING = 2'b01,
    S_STOPPED = 2'b10,
    S_LAP     = 2'b11
  } sw_state_e;

  localparam logic [ST_W-1:0] ST_IDLE    = 2'b00;
  localparam logic [ST_W-1:0] ST_RUNNING = 2'b01;
  localparam logic [ST_W-1:0] ST_STOPPED = 2'b10;
  localparam logic [ST_W-1:0] ST_LAP     = 2'b11;

  function automatic logic rise_of(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// Lap time FIFO: first-word-fall-through, overwrite-oldest when full,
// sticky overflow flag, synchronous flush.
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int LAP_DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  logic [CNT_W-1:0]             i_wdata,
  output logic [CNT_W-1:0]             o_rdata,
  output logic                         o_empty,
  output logic [$clog2(LAP_DEPTH):0]   o_num,
  output logic                         o_ovf
);

  localparam int AW = $clog2(LAP_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [NW-1:0] NUM_ONE  = NW'(1);
  localparam logic [NW-1:0] NUM_FULL = NW'(LAP_DEPTH);

  logic [CNT_W-1:0] r_mem [LAP_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [NW-1:0]    r_num;
  logic             r_ovf;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_wr_en;

  assign w_empty  = (r_num == '0);
  assign w_full   = (r_num == NUM_FULL);
  assign w_pop_ok = i_pop & ~w_empty;
  assign w_wr_en  = i_push & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_num  <= '0;
      r_ovf  <= 1'b0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_num  <= '0;
      r_ovf  <= 1'b0;
    end else if (i_push && w_pop_ok) begin
      // Simultaneous push and pop keeps occupancy; never an overwrite.
      r_wptr <= r_wptr + PTR_ONE;
      r_rptr <= r_rptr + PTR_ONE;
    end else if (i_push && w_full) begin
      r_wptr <= r_wptr + PTR_ONE;
      r_rptr <= r_rptr + PTR_ONE;
      r_ovf  <= 1'b1;
    end else if (i_push) begin
      r_wptr <= r_wptr + PTR_ONE;
      r_num  <= r_num + NUM_ONE;
    end else if (w_pop_ok) begin
      r_rptr <= r_rptr + PTR_ONE;
      r_num  <= r_num - NUM_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rptr];
  assign o_empty = w_empty;
  assign o_num   = r_num;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button edge detection, run/stop/lap FSM,
// display hold timer and lap recording into lap_fifo.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int LAP_DEPTH   = 8,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic                         i_sclk,
  input  logic                         i_reset_n,
  input  logic                         i_start_stop,
  input  logic                         i_lap_reset,
  input  logic [CNT_W-1:0]             i_count,
  input  logic                         i_lap_rd,
  output logic                         o_count_init,
  output logic                         o_count_enb,
  output logic                         o_latch_count,
  output logic                         o_disp_hold,
  output logic [CNT_W-1:0]             o_lap_value,
  output logic                         o_lap_empty,
  output logic [$clog2(LAP_DEPTH):0]   o_lap_num,
  output logic                         o_lap_ovf,
  output logic [1:0]                   o_state
);

  localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  logic             r_start_prev;
  logic             r_lap_prev;
  logic [1:0]       r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_latch;

  logic             w_start_rise;
  logic             w_lap_rise;
  logic [1:0]       w_nxt_state;
  logic             w_latch;
  logic             w_push;
  logic             w_flush;
  logic             w_tmr_load;

  assign w_start_rise = rise_of(i_start_stop, r_start_prev);
  assign w_lap_rise   = rise_of(i_lap_reset, r_lap_prev);

  // Start always outranks lap; in LAP any button outranks timer expiry.
  always_comb begin
    w_nxt_state = r_state;
    w_latch     = 1'b0;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    w_tmr_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_nxt_state = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (w_start_rise) begin
          w_nxt_state = ST_STOPPED;
          w_latch     = 1'b1;
        end else if (w_lap_rise) begin
          w_nxt_state = ST_LAP;
          w_latch     = 1'b1;
          w_push      = 1'b1;
          w_tmr_load  = 1'b1;
        end
      end
      ST_LAP: begin
        if (w_start_rise) begin
          w_nxt_state = ST_STOPPED;
          w_latch     = 1'b1;
        end else if (w_lap_rise) begin
          w_latch     = 1'b1;
          w_push      = 1'b1;
          w_tmr_load  = 1'b1;
        end else if (r_timer == '0) begin
          w_nxt_state = ST_RUNNING;
        end
      end
      ST_STOPPED: begin
        if (w_start_rise) begin
          w_nxt_state = ST_RUNNING;
        end else if (w_lap_rise) begin
          w_nxt_state = ST_IDLE;
          w_flush     = 1'b1;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_start_prev <= 1'b0;
      r_lap_prev   <= 1'b0;
      r_state      <= ST_IDLE;
      r_latch      <= 1'b0;
    end else begin
      r_start_prev <= i_start_stop;
      r_lap_prev   <= i_lap_reset;
      r_state      <= w_nxt_state;
      r_latch      <= w_latch;
    end
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_timer <= '0;
    end else if (w_tmr_load) begin
      r_timer <= TMR_LOAD;
    end else if ((r_state == ST_LAP) && (r_timer != '0)) begin
      r_timer <= r_timer - TMR_ONE;
    end
  end

  lap_fifo #(
    .CNT_W     (CNT_W),
    .LAP_DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .i_clk   (i_sclk),
    .i_rst_n (i_reset_n),
    .i_push  (w_push),
    .i_pop   (i_lap_rd),
    .i_flush (w_flush),
    .i_wdata (i_count),
    .o_rdata (o_lap_value),
    .o_empty (o_lap_empty),
    .o_num   (o_lap_num),
    .o_ovf   (o_lap_ovf)
  );

  assign o_count_init  = (r_state == ST_IDLE);
  assign o_count_enb   = (r_state == ST_RUNNING) || (r_state == ST_LAP);
  assign o_disp_hold   = (r_state == ST_STOPPED) || (r_state == ST_LAP);
  assign o_latch_count = r_latch;
  assign o_state       = r_state;

endmodule
